// File: rtl/qe_result_checker.sv
// Scoreboard for QE_M results: expected values are queued in a FIFO while idle,
// then each DUT result is popped and compared in order, with timeout and error capture.
module qe_result_checker #(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exp_wr,
    input  logic [15:0] exp_data,
    output logic        exp_full,
    input  logic        start,
    input  logic        clear,
    input  logic        dut_valid,
    input  logic [15:0] dut_result,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [15:0] match_count,
    output logic [15:0] error_count,
    output logic [15:0] spurious_count,
    output logic        mismatch,
    output logic [15:0] mismatch_index,
    output logic [15:0] mismatch_got,
    output logic [15:0] mismatch_exp
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
    localparam logic [TW-1:0] TO_ONE  = TW'(1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        state_r;
    logic [15:0]   mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [TW-1:0] idle_cnt_r;
    logic [15:0]   index_r;
    logic [15:0]   match_count_r;
    logic [15:0]   error_count_r;
    logic [15:0]   spurious_count_r;
    logic          timeout_r;
    logic          mismatch_r;
    logic [15:0]   mismatch_index_r;
    logic [15:0]   mismatch_got_r;
    logic [15:0]   mismatch_exp_r;

    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic          push_s;
    logic [15:0]   head_s;
    logic          match_s;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

    assign fifo_full_s  = (count_r == CNT_MAX);
    assign fifo_empty_s = (count_r == {CW{1'b0}});
    assign push_s       = (state_r == ST_IDLE) && exp_wr && !fifo_full_s;
    assign head_s       = mem_r[rd_ptr_r];
    assign match_s      = (head_s == dut_result);

    assign exp_full       = fifo_full_s || (state_r != ST_IDLE);
    assign busy           = (state_r == ST_RUN);
    assign done           = (state_r == ST_DONE);
    assign pass           = done && (error_count_r == 16'd0) && !timeout_r && (spurious_count_r == 16'd0);
    assign timeout        = timeout_r;
    assign match_count    = match_count_r;
    assign error_count    = error_count_r;
    assign spurious_count = spurious_count_r;
    assign mismatch       = mismatch_r;
    assign mismatch_index = mismatch_index_r;
    assign mismatch_got   = mismatch_got_r;
    assign mismatch_exp   = mismatch_exp_r;

    // FIFO storage; pointers are reset separately so the array needs no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= exp_data;
        end
    end

    // Control FSM, FIFO pointers, counters and mismatch capture.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state_r          <= ST_IDLE;
            wr_ptr_r         <= {AW{1'b0}};
            rd_ptr_r         <= {AW{1'b0}};
            count_r          <= {CW{1'b0}};
            idle_cnt_r       <= {TW{1'b0}};
            index_r          <= 16'd0;
            match_count_r    <= 16'd0;
            error_count_r    <= 16'd0;
            spurious_count_r <= 16'd0;
            timeout_r        <= 1'b0;
            mismatch_r       <= 1'b0;
            mismatch_index_r <= 16'd0;
            mismatch_got_r   <= 16'd0;
            mismatch_exp_r   <= 16'd0;
        end else begin
            mismatch_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (push_s) begin
                        wr_ptr_r <= wr_ptr_r + PTR_ONE;
                        count_r  <= count_r + CNT_ONE;
                    end
                    if (dut_valid) begin
                        spurious_count_r <= sat_inc(spurious_count_r);
                    end
                    // Emptiness is judged before any same-cycle push.
                    if (start) begin
                        if (!fifo_empty_s) begin
                            state_r    <= ST_RUN;
                            index_r    <= 16'd0;
                            idle_cnt_r <= {TW{1'b0}};
                        end else begin
                            state_r <= ST_DONE;
                        end
                    end
                end
                ST_RUN: begin
                    if (dut_valid) begin
                        rd_ptr_r   <= rd_ptr_r + PTR_ONE;
                        count_r    <= count_r - CNT_ONE;
                        index_r    <= sat_inc(index_r);
                        idle_cnt_r <= {TW{1'b0}};
                        if (match_s) begin
                            match_count_r <= sat_inc(match_count_r);
                        end else begin
                            error_count_r    <= sat_inc(error_count_r);
                            mismatch_r       <= 1'b1;
                            mismatch_index_r <= index_r;
                            mismatch_got_r   <= dut_result;
                            mismatch_exp_r   <= head_s;
                        end
                        if (count_r == CNT_ONE) begin
                            state_r <= ST_DONE;
                        end
                    end else if (idle_cnt_r == TO_LAST) begin
                        timeout_r <= 1'b1;
                        state_r   <= ST_DONE;
                    end else begin
                        idle_cnt_r <= idle_cnt_r + TO_ONE;
                    end
                end
                ST_DONE: begin
                    if (dut_valid) begin
                        spurious_count_r <= sat_inc(spurious_count_r);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qe_result_checker.sv
// Self-checking bench for qe_result_checker: directed scenarios plus randomized
// runs scored against a queue-based model of the expected-result scoreboard.
module tb_qe_result_checker;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        exp_wr = 1'b0;
    logic [15:0] exp_data = 16'd0;
    logic        start = 1'b0;
    logic        clear = 1'b0;
    logic        dut_valid = 1'b0;
    logic [15:0] dut_result = 16'd0;
    logic        exp_full, busy, done, pass, timeout, mismatch;
    logic [15:0] match_count, error_count, spurious_count;
    logic [15:0] mismatch_index, mismatch_got, mismatch_exp;

    int tests_run = 0;
    int fails = 0;

    qe_result_checker #(.DEPTH(16), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .exp_wr(exp_wr), .exp_data(exp_data),
        .exp_full(exp_full), .start(start), .clear(clear),
        .dut_valid(dut_valid), .dut_result(dut_result), .busy(busy),
        .done(done), .pass(pass), .timeout(timeout),
        .match_count(match_count), .error_count(error_count),
        .spurious_count(spurious_count), .mismatch(mismatch),
        .mismatch_index(mismatch_index), .mismatch_got(mismatch_got),
        .mismatch_exp(mismatch_exp)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] v);
        exp_wr = 1'b1; exp_data = v; tick(); exp_wr = 1'b0;
    endtask

    task automatic result(input logic [15:0] v);
        dut_valid = 1'b1; dut_result = v; tick(); dut_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1; tick(); clear = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; tick(); tick(); reset = 1'b0;
        tests_run++; if ({match_count, error_count, spurious_count, mismatch_index, mismatch_got, mismatch_exp} !== 96'd0) begin fails++; $display("FAIL reset_counters got %h want 0", {match_count, error_count, spurious_count, mismatch_index, mismatch_got, mismatch_exp}); end
        tests_run++; if ({mismatch, timeout, busy, done, pass, exp_full} !== 6'b000000) begin fails++; $display("FAIL reset_flags got %b want 000000", {mismatch, timeout, busy, done, pass, exp_full}); end
    endtask

    task automatic test_basic_match();
        do_clear();
        push(16'd6465); push(16'd3); pulse_start();
        tests_run++; if ({busy, done} !== 2'b10) begin fails++; $display("FAIL basic_busy got %b want 10", {busy, done}); end
        result(16'd6465);
        tests_run++; if ({match_count, done} !== {16'd1, 1'b0}) begin fails++; $display("FAIL basic_first got %0d/%b want 1/0", match_count, done); end
        result(16'd3);
        tests_run++; if ({match_count, error_count, done, pass} !== {16'd2, 16'd0, 2'b11}) begin fails++; $display("FAIL basic_done got m%0d e%0d d%b p%b want m2 e0 d1 p1", match_count, error_count, done, pass); end
    endtask

    task automatic test_mismatch();
        do_clear();
        push(16'd6465); push(16'd802); pulse_start();
        result(16'd6465);
        tests_run++; if (mismatch !== 1'b0) begin fails++; $display("FAIL mm_nopulse got %b want 0", mismatch); end
        result(16'd800);
        tests_run++; if ({mismatch, mismatch_index, mismatch_got, mismatch_exp} !== {1'b1, 16'd1, 16'd800, 16'd802}) begin fails++; $display("FAIL mm_capture got p%b i%0d g%0d e%0d want p1 i1 g800 e802", mismatch, mismatch_index, mismatch_got, mismatch_exp); end
        tests_run++; if ({error_count, match_count, done, pass} !== {16'd1, 16'd1, 2'b10}) begin fails++; $display("FAIL mm_status got e%0d m%0d d%b p%b want e1 m1 d1 p0", error_count, match_count, done, pass); end
        tick();
        tests_run++; if ({mismatch, mismatch_index, mismatch_got} !== {1'b0, 16'd1, 16'd800}) begin fails++; $display("FAIL mm_onepulse got p%b i%0d g%0d want p0 i1 g800", mismatch, mismatch_index, mismatch_got); end
    endtask

    task automatic test_full();
        do_clear();
        for (int i = 0; i < 16; i++) begin
            tests_run++; if (exp_full !== 1'b0) begin fails++; $display("FAIL full_early at %0d got %b want 0", i, exp_full); end
            push(16'(i * 7 + 1));
        end
        tests_run++; if (exp_full !== 1'b1) begin fails++; $display("FAIL full_flag got %b want 1", exp_full); end
        push(16'hBEEF);
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            tests_run++; if (done !== 1'b0) begin fails++; $display("FAIL full_early_done at %0d got %b want 0", i, done); end
            result(16'(i * 7 + 1));
        end
        tests_run++; if ({done, pass, match_count, error_count} !== {2'b11, 16'd16, 16'd0}) begin fails++; $display("FAIL full_done got d%b p%b m%0d e%0d want d1 p1 m16 e0", done, pass, match_count, error_count); end
    endtask

    task automatic test_timeout();
        do_clear();
        push(16'd10); push(16'd20); pulse_start();
        result(16'd10);
        for (int i = 0; i < 7; i++) tick();
        tests_run++; if ({done, timeout, busy} !== 3'b001) begin fails++; $display("FAIL to_early got d%b t%b b%b want d0 t0 b1", done, timeout, busy); end
        tick();
        tests_run++; if ({done, timeout, busy, pass, match_count} !== {4'b1100, 16'd1}) begin fails++; $display("FAIL to_fire got d%b t%b b%b p%b m%0d want d1 t1 b0 p0 m1", done, timeout, busy, pass, match_count); end
    endtask

    task automatic test_spurious();
        do_clear();
        pulse_start();
        tests_run++; if ({done, pass} !== 2'b11) begin fails++; $display("FAIL empty_start got d%b p%b want d1 p1", done, pass); end
        do_clear();
        result(16'd5); result(16'd6);
        pulse_start();
        tests_run++; if ({spurious_count, done, pass, match_count, error_count} !== {16'd2, 2'b10, 32'd0}) begin fails++; $display("FAIL spurious got s%0d d%b p%b m%0d e%0d want s2 d1 p0 m0 e0", spurious_count, done, pass, match_count, error_count); end
        result(16'd7);
        tests_run++; if ({spurious_count, done} !== {16'd3, 1'b1}) begin fails++; $display("FAIL spurious_done got s%0d d%b want s3 d1", spurious_count, done); end
    endtask

    task automatic test_reset_mid_run();
        do_clear();
        push(16'd1); push(16'd2); push(16'd3); pulse_start();
        result(16'd9);
        reset = 1'b1; clear = 1'b1; tick(); reset = 1'b0; clear = 1'b0;
        tests_run++; if ({match_count, error_count, spurious_count, mismatch_index, mismatch_got, mismatch_exp} !== 96'd0) begin fails++; $display("FAIL midrst_counters got %h want 0", {match_count, error_count, spurious_count, mismatch_index, mismatch_got, mismatch_exp}); end
        tests_run++; if ({mismatch, timeout, busy, done, pass, exp_full} !== 6'b000000) begin fails++; $display("FAIL midrst_flags got %b want 000000", {mismatch, timeout, busy, done, pass, exp_full}); end
        push(16'd44); push(16'd55); pulse_start();
        result(16'd44); result(16'd55);
        tests_run++; if ({done, pass, match_count} !== {2'b11, 16'd2}) begin fails++; $display("FAIL midrst_rerun got d%b p%b m%0d want d1 p1 m2", done, pass, match_count); end
    endtask

    task automatic test_clear_priority();
        do_clear();
        push(16'd100);
        clear = 1'b1; start = 1'b1; exp_wr = 1'b1; exp_data = 16'd7; dut_valid = 1'b1; dut_result = 16'd7;
        tick();
        clear = 1'b0; start = 1'b0; exp_wr = 1'b0; dut_valid = 1'b0;
        tests_run++; if ({busy, done, exp_full, spurious_count} !== {3'b000, 16'd0}) begin fails++; $display("FAIL clr_prio got b%b d%b f%b s%0d want 0 0 0 0", busy, done, exp_full, spurious_count); end
        pulse_start();
        tests_run++; if ({done, pass} !== 2'b11) begin fails++; $display("FAIL clr_emptied got d%b p%b want d1 p1", done, pass); end
    endtask

    task automatic test_random();
        logic [15:0] q[$];
        logic [15:0] e, g;
        int n, sp, m, er, li, lg, le, idx;
        for (int it = 0; it < 20; it++) begin
            do_clear();
            q = {}; m = 0; er = 0; li = 0; lg = 0; le = 0; idx = 0;
            sp = $urandom_range(0, 3) == 0 ? 1 : 0;
            if (sp != 0) result(16'($urandom));
            n = $urandom_range(1, 18);
            for (int i = 0; i < n; i++) begin
                e = 16'($urandom);
                if (q.size() < 16) q.push_back(e);
                push(e);
            end
            tests_run++; if (exp_full !== (q.size() == 16)) begin fails++; $display("FAIL rnd_full it%0d got %b want %b", it, exp_full, q.size() == 16); end
            pulse_start();
            tests_run++; if ({busy, exp_full} !== 2'b11) begin fails++; $display("FAIL rnd_busy it%0d got %b want 11", it, {busy, exp_full}); end
            while (q.size() > 0) begin
                repeat ($urandom_range(0, 3)) tick();
                e = q.pop_front();
                g = ($urandom_range(0, 3) == 0) ? (e ^ 16'($urandom_range(1, 65535))) : e;
                result(g);
                if (g == e) m++;
                else begin er++; li = idx; lg = g; le = e; end
                idx++;
                tests_run++; if (mismatch !== (g != e)) begin fails++; $display("FAIL rnd_pulse it%0d idx%0d got %b want %b", it, idx - 1, mismatch, g != e); end
            end
            tests_run++; if ({match_count, error_count, spurious_count} !== {16'(m), 16'(er), 16'(sp)}) begin fails++; $display("FAIL rnd_counts it%0d got m%0d e%0d s%0d want m%0d e%0d s%0d", it, match_count, error_count, spurious_count, m, er, sp); end
            tests_run++; if ({done, pass, timeout} !== {1'b1, (er == 0 && sp == 0), 1'b0}) begin fails++; $display("FAIL rnd_status it%0d got d%b p%b t%b want d1 p%b t0", it, done, pass, timeout, er == 0 && sp == 0); end
            if (er > 0) begin
                tests_run++; if ({mismatch_index, mismatch_got, mismatch_exp} !== {16'(li), 16'(lg), 16'(le)}) begin fails++; $display("FAIL rnd_capture it%0d got i%0d g%0d e%0d want i%0d g%0d e%0d", it, mismatch_index, mismatch_got, mismatch_exp, li, lg, le); end
            end
            start = 1'b1; exp_wr = 1'b1; exp_data = 16'd1; tick(); start = 1'b0; exp_wr = 1'b0;
            tests_run++; if ({done, busy, exp_full, match_count, error_count} !== {3'b101, 16'(m), 16'(er)}) begin fails++; $display("FAIL rnd_hold it%0d got d%b b%b f%b m%0d e%0d want d1 b0 f1 m%0d e%0d", it, done, busy, exp_full, match_count, error_count, m, er); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_match();
        test_mismatch();
        test_full();
        test_timeout();
        test_spurious();
        test_reset_mid_run();
        test_clear_priority();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/qe_result_checker.md
QE_RESULT_CHECKER -- requirements
Module: qe_result_checker

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning expected-result FIFO depth (power of 2, 2..256).
REQ-002 SHALL have parameter TIMEOUT, default 1024, meaning the maximum number of idle cycles allowed between DUT results while running.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-005 SHALL have port exp_wr, input, 1, push strobe for an expected result.
REQ-006 SHALL have port exp_data, input, 16, the expected result value.
REQ-007 SHALL have port exp_full, output, 1, meaning the FIFO is full or the state is not IDLE (push not accepted).
REQ-008 SHALL have port start, input, 1, which begins checking.
REQ-009 SHALL have port clear, input, 1, which aborts and empties the block.
REQ-010 SHALL have port dut_valid, input, 1, driven from the QE_M valid_out.
REQ-011 SHALL have port dut_result, input, 16, driven from the QE_M result.
REQ-012 SHALL have port busy, output, 1, meaning state is RUN.
REQ-013 SHALL have port done, output, 1, meaning state is DONE.
REQ-014 SHALL have port pass, output, 1, meaning done with zero errors, no timeout and no spurious results.
REQ-015 SHALL have port timeout, output, 1, a sticky flag indicating a run timeout.
REQ-016 SHALL have port match_count, output, 16, the number of matching results.
REQ-017 SHALL have port error_count, output, 16, the number of mismatching results.
REQ-018 SHALL have port spurious_count, output, 16, the number of dut_valid pulses seen outside RUN.
REQ-019 SHALL have port mismatch, output, 1, a one-cycle pulse per mismatch.
REQ-020 SHALL have port mismatch_index, output, 16, the 0-based index of the most recent mismatch.
REQ-021 SHALL have port mismatch_got, output, 16, the DUT value at the most recent mismatch.
REQ-022 SHALL have port mismatch_exp, output, 16, the expected value at the most recent mismatch.

Function
REQ-023 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-024 IDLE SHALL write exp_data into the FIFO when exp_wr=1 and the FIFO is not full; exp_wr SHALL be ignored when the FIFO is full or the state is not IDLE, with no overwrite.
REQ-025 IDLE SHALL go to RUN on start=1 with the FIFO non-empty; start with the FIFO empty SHALL go directly to DONE with pass=1.
REQ-026 In RUN, each cycle with dut_valid=1 SHALL pop the FIFO head and compare it with dut_result combinationally; the counters SHALL update on the same edge.
REQ-027 On a match, match_count SHALL increment.
REQ-028 On a mismatch, error_count SHALL increment; mismatch SHALL be 1 in the following cycle; mismatch_index/got/exp SHALL be registered with the compare index, dut_result and the FIFO head.
REQ-029 The compare index SHALL start at 0 on each start and increment per pop.
REQ-030 All 16-bit counters SHALL saturate at 16'hFFFF.
REQ-031 Popping the last FIFO entry SHALL move the FSM to DONE on the same edge (done=1 the next cycle, zero extra latency).
REQ-032 RUN SHALL count consecutive cycles with dut_valid=0; reaching TIMEOUT SHALL set timeout=1 and go to DONE, leaving the remaining FIFO entries unconsumed.
REQ-033 dut_valid=1 in IDLE or DONE SHALL increment spurious_count only; the FIFO and other counters SHALL be unchanged.
REQ-034 DONE SHALL hold all outputs stable; start in DONE SHALL be ignored.
REQ-035 clear=1 in any state SHALL, on the next edge, go to IDLE, empty the FIFO, zero all counters and flags, and deassert mismatch; clear SHALL take priority over start, exp_wr and dut_valid in the same cycle.
REQ-036 pass SHALL equal done AND error_count==0 AND timeout==0 AND spurious_count==0.

Reset
REQ-037 reset=1 SHALL, on the next rising edge, force IDLE, empty the FIFO, and zero match_count, error_count, spurious_count, mismatch_index, mismatch_got, mismatch_exp, mismatch, timeout, busy, done and pass.
REQ-038 After reset, exp_full SHALL be 0.
REQ-039 Reset SHALL override clear and all other inputs, including when asserted mid-RUN.

Verification
REQ-040 Push 6465 and 3, start, dut_valid with 6465 then 3 on consecutive cycles -> match_count=2, error_count=0, done=1 and pass=1 the cycle after the second result.
REQ-041 Push 6465 and 802, start, results 6465 then 800 -> one mismatch pulse, mismatch_index=1, mismatch_got=800, mismatch_exp=802, pass=0.
REQ-042 Push 16 entries, attempt a 17th -> exp_full=1, the 17th is dropped, and 16 matching results lead to DONE with match_count=16.
REQ-043 TIMEOUT=8, push 2 entries, start, one result then silence -> timeout=1 and done exactly 8 cycles after the last dut_valid, with match_count=1.
REQ-044 dut_valid pulsed twice in IDLE, then an empty start -> spurious_count=2, done=1, pass=0.
REQ-045 reset asserted mid-RUN after 1 of 3 results -> all outputs zero next cycle, exp_full=0, and a new push/start sequence checks correctly.
